// File: rtl/template_chain_loader_pkg.sv
// Shared types and default geometry for the template register chain loader.
// The default WIDTH/DIV are also used when instantiating the chain itself.
package template_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        XFER  = 2'd2,
        FIN   = 2'd3
    } loader_state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DIV   = 1;

endpackage

// File: rtl/template_chain_loader_if.sv
// Word handshake between the host command decoder (master) and the loader (slave).
interface template_chain_loader_if
    import template_loader_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] IN_DATA;
    logic             IN_LAST;

    modport master (
        output IN_VALID,
        output IN_DATA,
        output IN_LAST,
        input  IN_READY
    );

    modport slave (
        input  IN_VALID,
        input  IN_DATA,
        input  IN_LAST,
        output IN_READY
    );

endinterface

// File: rtl/template_chain_loader_shift_tick_gen.sv
// Serial bit prescaler: counts 0..DIV-1 while enabled and flags the last cycle of each bit.
module shift_tick_gen #(
    parameter int DIV = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int              CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   TOP = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

    assign tick = (cnt == TOP);

endmodule

// File: rtl/template_chain_loader.sv
// Serialises template words MSB first onto D/LOAD and commits a finished frame with
// a single TRANSFER pulse, followed by a one-cycle DONE.
module template_chain_loader
    import template_loader_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIV   = DEF_DIV
) (
    input  logic                    CLK,
    input  logic                    RST,
    template_chain_loader_if.slave  in_if,
    output logic                    D,
    output logic                    LOAD,
    output logic                    TRANSFER,
    output logic                    BUSY,
    output logic                    DONE
);

    localparam int            BW       = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    loader_state_t    state;
    logic [WIDTH-1:0] sr;
    logic [BW-1:0]    bit_cnt;
    logic             last_q;
    logic             tick;
    logic             accept;
    logic             shifting;
    logic             load_i;

    // Ready is masked by RST directly so no word can be taken during reset.
    assign in_if.IN_READY = (state == IDLE) && !RST;
    assign accept         = in_if.IN_VALID && in_if.IN_READY;
    assign shifting       = (state == SHIFT);
    assign load_i         = shifting && tick;

    shift_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .CLK  (CLK),
        .RST  (RST),
        .clr  (accept),
        .en   (shifting),
        .tick (tick)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            bit_cnt <= '0;
            last_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                        last_q  <= in_if.IN_LAST;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        bit_cnt <= bit_cnt + BW'(1);
                        if (bit_cnt == LAST_BIT) begin
                            // XFER is a separate state, so TRANSFER can never share a cycle with LOAD.
                            state <= last_q ? XFER : IDLE;
                        end
                    end
                end
                XFER:    state <= FIN;
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Data path: no reset, D is gated by state instead.
    always_ff @(posedge CLK) begin
        if (accept) begin
            sr <= in_if.IN_DATA;
        end else if (load_i) begin
            sr <= sr << 1;
        end
    end

    assign D        = shifting && sr[WIDTH-1];
    assign LOAD     = load_i;
    assign TRANSFER = (state == XFER);
    assign DONE     = (state == FIN);
    assign BUSY     = (state != IDLE);

endmodule

// File: tb/tb_template_chain_loader.sv
// Scoreboard bench for template_chain_loader over several WIDTH/DIV geometries.
module tb_template_chain_loader;

    localparam int NCFG   = 4;
    localparam int K_LOAD = 0;
    localparam int K_XFER = 1;
    localparam int K_DONE = 2;
    localparam int OP_WORD  = 0;
    localparam int OP_ABORT = 1;

    typedef struct {
        int   kind;
        int   cyc;
        logic d;
    } exp_t;

    typedef struct {
        int          kind;
        logic [31:0] data;
        bit          last;
        int          gap;
    } op_t;

    function automatic int cfg_w(int i);
        case (i)
            0:       return 8;
            1:       return 8;
            2:       return 1;
            default: return 5;
        endcase
    endfunction

    function automatic int cfg_d(int i);
        case (i)
            0:       return 1;
            1:       return 3;
            2:       return 1;
            default: return 2;
        endcase
    endfunction

    logic clk = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   ndone = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(int cfg, string name, logic [63:0] got, logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL c%0d %s: got %0h expected %0h", cfg, name, got, exp);
        end
    endfunction

    function automatic void mark_done();
        ndone++;
    endfunction

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int W  = cfg_w(g);
        localparam int DV = cfg_d(g);

        logic        rst;
        logic [31:0] data_v;
        logic        d, load, xfer, busy, donep;
        exp_t        q[$];
        int          xfer_seen = 0;
        int          lasts_sent = 0;

        template_chain_loader_if #(.WIDTH(W)) bus ();

        template_chain_loader #(
            .WIDTH (W),
            .DIV   (DV)
        ) dut (
            .CLK      (clk),
            .RST      (rst),
            .in_if    (bus),
            .D        (d),
            .LOAD     (load),
            .TRANSFER (xfer),
            .BUSY     (busy),
            .DONE     (donep)
        );

        assign bus.IN_DATA = data_v[W-1:0];

        initial begin : mon
            exp_t e;
            int   kind;
            forever begin
                @(posedge clk);
                #1;
                chk(g, "load_xfer_mutex", 64'(load & xfer), 64'd0);
                if (!busy) chk(g, "d_idle", 64'(d), 64'd0);
                if (load || xfer || donep) begin
                    if (q.size() == 0) begin
                        chk(g, "unexpected_strobe", {61'd0, load, xfer, donep}, 64'd0);
                    end else begin
                        e    = q.pop_front();
                        kind = load ? K_LOAD : (xfer ? K_XFER : K_DONE);
                        chk(g, "strobe_kind", 64'(kind), 64'(e.kind));
                        chk(g, "strobe_cycle", 64'(cyc), 64'(e.cyc));
                        if (load) chk(g, "d_bit", 64'(d), 64'(e.d));
                        if (xfer) xfer_seen++;
                    end
                end
            end
        end

        initial begin : drv
            op_t ops[$];
            int  a;
            int  exp_ready;
            int  bound;
            bit  have_prev;

            rst          = 1'b1;
            bus.IN_VALID = 1'b1;
            bus.IN_LAST  = 1'b1;
            data_v       = '1;
            repeat (3) begin
                @(negedge clk);
                chk(g, "reset_outs", {58'd0, bus.IN_READY, d, load, xfer, busy, donep}, 64'd0);
            end
            rst          = 1'b0;
            bus.IN_VALID = 1'b0;
            @(negedge clk);
            chk(g, "ready_after_rst", 64'(bus.IN_READY), 64'd1);

            case (g)
                0: begin
                    ops.push_back('{OP_WORD,  32'hA5, 1'b1, 0});
                    ops.push_back('{OP_WORD,  32'hFF, 1'b0, 2});
                    ops.push_back('{OP_WORD,  32'h00, 1'b1, 0});
                    ops.push_back('{OP_ABORT, 32'h5A, 1'b1, 1});
                    ops.push_back('{OP_WORD,  32'h3C, 1'b1, 1});
                end
                1: ops.push_back('{OP_WORD, 32'h81, 1'b1, 0});
                2: begin
                    ops.push_back('{OP_WORD, 32'h1, 1'b1, 0});
                    ops.push_back('{OP_WORD, 32'h0, 1'b1, 0});
                    ops.push_back('{OP_WORD, 32'h1, 1'b0, 0});
                    ops.push_back('{OP_WORD, 32'h0, 1'b1, 0});
                end
                default: begin
                    ops.push_back('{OP_WORD, 32'h15, 1'b0, 0});
                    ops.push_back('{OP_WORD, 32'h0A, 1'b1, 0});
                end
            endcase
            for (int i = 0; i < 12; i++) begin
                ops.push_back('{OP_WORD, $urandom, ($urandom_range(0, 1) == 1) || (i == 11),
                                int'($urandom_range(0, 3))});
            end

            have_prev = 1'b0;
            exp_ready = 0;
            foreach (ops[i]) begin
                if (ops[i].gap > 0) begin
                    bus.IN_VALID = 1'b0;
                    repeat (ops[i].gap) @(negedge clk);
                end
                data_v       = ops[i].data;
                bus.IN_LAST  = ops[i].last;
                bus.IN_VALID = 1'b1;
                bound = 0;
                while (!bus.IN_READY && bound < 500) begin
                    @(negedge clk);
                    bound++;
                end
                chk(g, "ready_seen", 64'(bus.IN_READY), 64'd1);
                if (!bus.IN_READY) break;
                if (have_prev && ops[i].gap == 0) chk(g, "ready_cycle", 64'(cyc), 64'(exp_ready));

                // Handshake happens at the coming edge; that edge starts cycle 1.
                a = cyc + 1;
                for (int k = 0; k < W; k++) begin
                    q.push_back('{K_LOAD, a + (k + 1) * DV - 1, ops[i].data[W-1-k]});
                end
                if (ops[i].last) begin
                    q.push_back('{K_XFER, a + W * DV, 1'b0});
                    q.push_back('{K_DONE, a + W * DV + 1, 1'b0});
                    lasts_sent++;
                end
                exp_ready = a + W * DV + (ops[i].last ? 2 : 0);
                have_prev = 1'b1;
                @(negedge clk);
                chk(g, "busy_after_accept", {62'd0, busy, bus.IN_READY}, 64'b10);

                if (ops[i].kind == OP_ABORT) begin
                    bus.IN_VALID = 1'b0;
                    while (cyc < a + 4 * DV - 1) @(negedge clk);
                    rst = 1'b1;
                    q.delete();
                    lasts_sent--;
                    @(negedge clk);
                    chk(g, "abort_outs", {58'd0, bus.IN_READY, d, load, xfer, busy, donep}, 64'd0);
                    rst = 1'b0;
                    @(negedge clk);
                    chk(g, "abort_ready", 64'(bus.IN_READY), 64'd1);
                    repeat (3) @(negedge clk);
                    have_prev = 1'b0;
                end
            end
            bus.IN_VALID = 1'b0;

            for (int t = 0; t < 500 && q.size() != 0; t++) @(negedge clk);
            repeat (4) @(negedge clk);
            chk(g, "queue_drained", 64'(q.size()), 64'd0);
            chk(g, "transfer_count", 64'(xfer_seen), 64'(lasts_sent));
            mark_done();
        end
    end

    initial begin : main
        for (int t = 0; t < 40000 && ndone < NCFG; t++) @(posedge clk);
        chk(-1, "all_configs_done", 64'(ndone), 64'(NCFG));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
